hazard_unit: RTL and testbench

- Consumer end of the pipeline control interface. Takes the controller's E/M/W-stage control bits (ResultSrcEb0, RegWriteM, RegWriteW, PCSrcE) and the datapath register addresses.
- Produces the stall, flush and forwarding signals that drive the pipeline registers (FlushE and friends).
- Adds a data-memory wait FSM with a timeout, plus saturating stall and flush event counters for performance debug.
- Sits beside the controller and datapath in the 5-stage RV32I core.

---
 rtl/hazard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for the 5-stage RV32I core: forwarding selects, stall/flush
// controls, a data-memory wait FSM with timeout, and saturating stall/flush counters.
module hazard_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcEb0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } memState_t;

    localparam int WCW = $clog2(MAX_WAIT + 1);

    memState_t      state;
    logic [WCW-1:0] waitCnt;
    logic           lwStall;
    logic           memStall;

    // M-stage result is newer than W-stage, so it wins when both match.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (Rs1E == RdM)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (Rs1E == RdW)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (Rs2E == RdM)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (Rs2E == RdW)) begin
            ForwardBE = 2'b01;
        end
    end

    assign lwStall = ResultSrcEb0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    // A ready in WAIT releases the pipeline in the same cycle, not one later.
    always_comb begin
        memStall = 1'b0;
        case (state)
            RUN:     memStall = MemReqM && !MemReadyM;
            WAIT:    memStall = !MemReadyM;
            TMO:     memStall = 1'b1;
            default: memStall = 1'b0;
        endcase
    end

    // A memory stall freezes E, so any pending redirect is held there and
    // applied once the stall lifts.
    assign StallF = lwStall || memStall;
    assign StallD = lwStall || memStall;
    assign StallE = memStall;
    assign StallM = memStall;
    assign FlushW = memStall;
    assign FlushD = PCSrcE && !memStall;
    assign FlushE = (lwStall || PCSrcE) && !memStall;

    assign dbgState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            waitCnt    <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state   <= WAIT;
                        waitCnt <= WCW'(1);
                    end
                end
                WAIT: begin
                    if (MemReadyM) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt == WCW'(MAX_WAIT - 1)) begin
                        state      <= TMO;
                        MemTimeout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WCW'(1);
                    end
                end
                TMO: begin
                    MemTimeout <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && (StallCnt != '1)) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (FlushE && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with small counter width and short timeout so
// saturation and the timeout path are reachable in a few dozen cycles.
module tb_hazard_unit;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcEb0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    logic [1:0]       dbgState;

    logic [10:0]        exp_q[$];
    logic [2*CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0]   expStall;
    logic [CNT_W-1:0]   expFlush;
    int                 total = 0;
    int                 bad   = 0;

    logic [10:0] obsCtrl;
    assign obsCtrl = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcEb0(ResultSrcEb0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
        .dbgState(dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    // driver tasks
    task automatic clearInputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        ResultSrcEb0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    // scoreboard
    task automatic chkCtrl(input string tag);
        logic [10:0] want;
        want = exp_q.pop_front();
        total++;
        assert (obsCtrl === want) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obsCtrl, want);
        end
    endtask

    task automatic chkCnt(input string tag);
        logic [2*CNT_W-1:0] want;
        cnt_q.push_back({expStall, expFlush});
        want = cnt_q.pop_front();
        total++;
        assert ({StallCnt, FlushCnt} === want) else begin
            bad++;
            $error("FAIL %s observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, StallCnt, FlushCnt, want[2*CNT_W-1:CNT_W], want[CNT_W-1:0]);
        end
    endtask

    task automatic chkBits(input string tag, input logic [1:0] obs, input logic [1:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    // Inputs are already driven; expected vector is {fa, fb, sF, sD, sE, sM, fD, fE, fW}.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic sF, input logic sE, input logic fD, input logic fE);
        exp_q.push_back({fa, fb, sF, sF, sE, sE, fD, fE, sE});
        #2;
        chkCtrl(tag);
        if (sF && (expStall != '1)) expStall = expStall + 1'b1;
        if (fE && (expFlush != '1)) expFlush = expFlush + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        expStall = '0;
        expFlush = '0;
        clearInputs();
        reset = 1'b0;
        #3;
        exp_q.push_back(11'b0);
        chkCtrl("reset_ctrl");
        chkCnt("reset_cnt");
        chkBits("reset_state", dbgState, 2'd0);
        chkBits("reset_tmo", {1'b0, MemTimeout}, 2'b00);
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;

        step("idle", 2'b00, 2'b00, 0, 0, 0, 0);

        // load-use
        ResultSrcEb0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        step("loaduse_rs1", 2'b00, 2'b00, 1, 0, 0, 1);
        chkCnt("loaduse_cnt");
        RdE = 5'd0; Rs1D = 5'd0;
        step("loaduse_rd0", 2'b00, 2'b00, 0, 0, 0, 0);
        RdE = 5'd7; Rs1D = 5'd5; Rs2D = 5'd7;
        step("loaduse_rs2", 2'b00, 2'b00, 1, 0, 0, 1);
        clearInputs();

        // forwarding
        RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3;
        step("fwd_m_prio", 2'b10, 2'b00, 0, 0, 0, 0);
        RegWriteM = 1'b0;
        step("fwd_w", 2'b01, 2'b00, 0, 0, 0, 0);
        RegWriteM = 1'b1; RdM = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        step("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 0);
        RdM = 5'd9; Rs1E = 5'd3; Rs2E = 5'd9;
        step("fwd_mixed", 2'b01, 2'b10, 0, 0, 0, 0);
        clearInputs();

        // branch, then branch held through a 3-cycle memory wait
        PCSrcE = 1'b1;
        step("branch", 2'b00, 2'b00, 0, 0, 1, 1);
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) step("memwait", 2'b00, 2'b00, 1, 1, 0, 0);
        chkBits("memwait_state", dbgState, 2'd1);
        MemReadyM = 1'b1;
        step("mem_release", 2'b00, 2'b00, 0, 0, 1, 1);
        chkBits("mem_run_state", dbgState, 2'd0);
        PCSrcE = 1'b0; MemReqM = 1'b0;
        step("ready_no_req", 2'b00, 2'b00, 0, 0, 0, 0);
        chkCnt("mem_cnt");
        clearInputs();

        // counter saturation
        ResultSrcEb0 = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
        for (int i = 0; i < 20; i++) step("sat_lw", 2'b00, 2'b00, 1, 0, 0, 1);
        chkCnt("sat_cnt");
        chkBits("sat_stall_max", {1'b0, &StallCnt}, 2'b01);
        clearInputs();

        // timeout
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            chkBits("tmo_pre", {1'b0, MemTimeout}, 2'b00);
            step("tmo_wait", 2'b00, 2'b00, 1, 1, 0, 0);
        end
        chkBits("tmo_flag", {1'b0, MemTimeout}, 2'b01);
        chkBits("tmo_state", dbgState, 2'd2);
        MemReadyM = 1'b1;
        step("tmo_hold", 2'b00, 2'b00, 1, 1, 0, 0);
        chkBits("tmo_sticky", {1'b0, MemTimeout}, 2'b01);
        chkCnt("tmo_cnt");

        // asynchronous reset mid-timeout
        #2;
        reset = 1'b0;
        #1;
        expStall = '0;
        expFlush = '0;
        exp_q.push_back(11'b0);
        chkCtrl("async_rst_ctrl");
        chkCnt("async_rst_cnt");
        chkBits("async_rst_tmo", {1'b0, MemTimeout}, 2'b00);
        chkBits("async_rst_state", dbgState, 2'd0);
        #4;
        reset = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        step("post_reset", 2'b00, 2'b00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
